cubic_poly_inv: RTL



---
 rtl/poly_pkg.sv | 14 +
 rtl/poly_cube.sv | 22 ++
 rtl/cubic_poly_inv.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/poly_pkg.sv
// Shared definitions for the cubic polynomial datapath: default widths and the
// state encoding used by the inverse search FSM.
package poly_pkg;

  localparam int POLY_XW = 2;
  localparam int POLY_KW = 2;

  typedef logic [1:0] poly_state_t;

  localparam poly_state_t ST_IDLE = 2'd0;
  localparam poly_state_t ST_CALC = 2'd1;
  localparam poly_state_t ST_DONE = 2'd2;

endpackage

// File: rtl/poly_cube.sv
// Combinational cube unit: XW-bit x in, 3*XW-bit x*x*x out. The full-width
// product cannot overflow, so no saturation is needed.
module poly_cube
  import poly_pkg::*;
#(
  parameter  int XW = POLY_XW,
  localparam int YW = 3 * XW
) (
  input  logic [XW-1:0] x_i,
  output logic [YW-1:0] cube_o
);

  logic [2*XW-1:0] sq;
  logic [YW-1:0]   sq_ext;
  logic [YW-1:0]   x_ext;

  assign sq     = {{XW{1'b0}}, x_i} * {{XW{1'b0}}, x_i};
  assign sq_ext = {{XW{1'b0}}, sq};
  assign x_ext  = {{(2*XW){1'b0}}, x_i};
  assign cube_o = sq_ext * x_ext;

endmodule

// File: rtl/cubic_poly_inv.sv
// Bit-serial restoring inverse of y = x^3 + k: finds the largest x with x^3 <= y - k.
// Optional residue output (t - x^3) is built when POLY_INV_RESIDUE_EN is defined.
module cubic_poly_inv
  import poly_pkg::*;
#(
  parameter  int XW = POLY_XW,
  parameter  int KW = POLY_KW,
  localparam int YW = 3 * XW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [YW-1:0] y_in,
  input  logic [KW-1:0] k_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [XW-1:0] x_out,
  output logic          exact,
  output logic          underflow
`ifdef POLY_INV_RESIDUE_EN
  ,
  output logic [YW-1:0] residue
`endif
);

  localparam int IW = (XW > 1) ? $clog2(XW) : 1;

  poly_state_t   state_q, state_d;
  logic [YW-1:0] t_q, t_d;
  logic [XW-1:0] x_acc_q, x_acc_d;
  logic [IW-1:0] i_q, i_d;
  logic          underflow_q, underflow_d;
  logic          exact_q, exact_d;

  logic [YW:0]   t_full;
  logic [XW-1:0] bit_sel;
  logic [XW-1:0] cand;
  logic [YW-1:0] cand_cube;
  logic [XW-1:0] x_keep;
  logic [YW-1:0] chk_cube;

  // One extra bit so a negative difference shows up as the MSB.
  assign t_full  = {1'b0, y_in} - (YW+1)'(k_in);
  assign bit_sel = XW'(1) << i_q;
  assign cand    = x_acc_q | bit_sel;
  assign x_keep  = (cand_cube <= t_q) ? cand : x_acc_q;

  poly_cube #(.XW(XW)) u_cube_cand (
    .x_i    (cand),
    .cube_o (cand_cube)
  );

  // Checks the value the search is about to commit, so exact/residue can be
  // registered on the same edge that enters DONE.
  poly_cube #(.XW(XW)) u_cube_chk (
    .x_i    (x_keep),
    .cube_o (chk_cube)
  );

`ifdef POLY_INV_RESIDUE_EN
  logic [YW-1:0] residue_q, residue_d;
`endif

  always_comb begin
    state_d     = state_q;
    t_d         = t_q;
    x_acc_d     = x_acc_q;
    i_d         = i_q;
    underflow_d = underflow_q;
    exact_d     = exact_q;
`ifdef POLY_INV_RESIDUE_EN
    residue_d   = residue_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          t_d         = t_full[YW-1:0];
          x_acc_d     = '0;
          i_d         = IW'(XW - 1);
          exact_d     = 1'b0;
`ifdef POLY_INV_RESIDUE_EN
          residue_d   = '0;
`endif
          if (t_full[YW]) begin
            underflow_d = 1'b1;
            state_d     = ST_DONE;
          end else begin
            underflow_d = 1'b0;
            state_d     = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        x_acc_d = x_keep;
        if (i_q == '0) begin
          state_d   = ST_DONE;
          exact_d   = (chk_cube == t_q);
`ifdef POLY_INV_RESIDUE_EN
          residue_d = t_q - chk_cube;
`endif
        end else begin
          i_d = i_q - IW'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      t_q         <= '0;
      x_acc_q     <= '0;
      i_q         <= '0;
      underflow_q <= 1'b0;
      exact_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      t_q         <= t_d;
      x_acc_q     <= x_acc_d;
      i_q         <= i_d;
      underflow_q <= underflow_d;
      exact_q     <= exact_d;
    end
  end

`ifdef POLY_INV_RESIDUE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      residue_q <= '0;
    end else begin
      residue_q <= residue_d;
    end
  end

  assign residue = residue_q;
`endif

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign x_out     = x_acc_q;
  assign exact     = exact_q;
  assign underflow = underflow_q;

endmodule
